// File: rtl/work_block_loader_if.sv
// Handshake bundle between the loader, the SDRAM manager stream and the SHA-256d core.
// The loader uses the slave view; the manager/core side (or a bench) uses master.
interface work_block_loader_if;
  logic         in_valid;
  logic         in_first;
  logic [31:0]  in_data;
  logic         in_ready;

  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [95:0]  job_tail;
  logic [31:0]  job_nonce_start;
  logic [255:0] job_target;
  logic [31:0]  job_id;

  logic         res_valid;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic         res_ready;

  logic         wb_valid;
  logic [31:0]  wb_data;
  logic         wb_ready;

  modport slave (
    input  in_valid, in_first, in_data, job_ready, res_valid, res_found, res_nonce, wb_ready,
    output in_ready, job_valid, job_midstate, job_tail, job_nonce_start, job_target, job_id,
           res_ready, wb_valid, wb_data
  );

  modport master (
    output in_valid, in_first, in_data, job_ready, res_valid, res_found, res_nonce, wb_ready,
    input  in_ready, job_valid, job_midstate, job_tail, job_nonce_start, job_target, job_id,
           res_ready, wb_valid, wb_data
  );
endinterface

// File: rtl/work_block_loader.sv
// Assembles a streamed 24-word work block into a SHA-256d job, dispatches it to the core
// and streams the (status, nonce) result record back to the SDRAM manager.
module work_block_loader #(
  parameter int          DATAWIDTH        = 32,
  parameter int          BLOCK_WORDS      = 24,
  parameter logic [31:0] STATUS_FOUND     = 32'h5555_0001,
  parameter logic [31:0] STATUS_EXHAUSTED = 32'h5555_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  abort,
  output logic                  busy,
  output logic [7:0]            drop_cnt,
  work_block_loader_if.slave    bus
);

  localparam int                JOB_WORDS = 21;
  localparam int                IDX_W     = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    COLLECT,
    DISPATCH,
    MINING,
    WB_STATUS,
    WB_NONCE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [DATAWIDTH-1:0] blk [JOB_WORDS];
  logic [DATAWIDTH-1:0] nonce_q;
  logic                 in_ready;
  logic                 job_valid;
  logic                 res_ready;
  logic                 wb_valid;
  logic [DATAWIDTH-1:0] wb_data;

  // Words 21..23 of a block are accepted but never stored; only the job words live in blk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= COLLECT;
      idx       <= '0;
      for (int i = 0; i < JOB_WORDS; i++) blk[i] <= '0;
      nonce_q   <= '0;
      in_ready  <= 1'b1;
      job_valid <= 1'b0;
      res_ready <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
    end else if (abort) begin
      state     <= COLLECT;
      idx       <= '0;
      in_ready  <= 1'b1;
      job_valid <= 1'b0;
      res_ready <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            if (bus.in_first) begin
              blk[0] <= bus.in_data;
              idx    <= IDX_W'(1);
            end else if (idx == '0) begin
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else begin
              if (int'(idx) < JOB_WORDS) blk[idx] <= bus.in_data;
              if (idx == LAST_IDX) begin
                idx       <= '0;
                state     <= DISPATCH;
                in_ready  <= 1'b0;
                job_valid <= 1'b1;
                busy      <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
        end

        DISPATCH: begin
          if (bus.job_ready) begin
            state     <= MINING;
            job_valid <= 1'b0;
            res_ready <= 1'b1;
          end
        end

        // The status word is loaded here so it is already stable when wb_valid rises.
        MINING: begin
          if (bus.res_valid) begin
            state     <= WB_STATUS;
            res_ready <= 1'b0;
            wb_valid  <= 1'b1;
            wb_data   <= bus.res_found ? STATUS_FOUND : STATUS_EXHAUSTED;
            nonce_q   <= bus.res_found ? bus.res_nonce : '0;
          end
        end

        WB_STATUS: begin
          if (bus.wb_ready) begin
            state   <= WB_NONCE;
            wb_data <= nonce_q;
          end
        end

        WB_NONCE: begin
          if (bus.wb_ready) begin
            state    <= COLLECT;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        default: begin
          state    <= COLLECT;
          idx      <= '0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.job_valid       = job_valid;
  assign bus.res_ready       = res_ready;
  assign bus.wb_valid        = wb_valid;
  assign bus.wb_data         = wb_data;

  assign bus.job_midstate    = {blk[0], blk[1], blk[2], blk[3], blk[4], blk[5], blk[6], blk[7]};
  assign bus.job_tail        = {blk[8], blk[9], blk[10]};
  assign bus.job_nonce_start = blk[11];
  assign bus.job_target      = {blk[12], blk[13], blk[14], blk[15], blk[16], blk[17], blk[18], blk[19]};
  assign bus.job_id          = blk[20];

endmodule

// File: tb/tb_work_block_loader.sv
// Bench for work_block_loader: a block-level reference model checked every cycle,
// plus hand-computed literal expectations at key points of the directed sequence.
module tb_work_block_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       abort;
  logic       busy;
  logic [7:0] drop_cnt;

  work_block_loader_if bus ();

  work_block_loader dut (
    .clk      (clk),
    .reset    (reset),
    .abort    (abort),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0=collect 1=dispatch 2=mining 3=status word 4=nonce word.
  int          m_phase = 0;
  int          m_idx   = 0;
  int          m_drop  = 0;
  logic [31:0] m_words [24];
  logic [31:0] m_status = '0;
  logic [31:0] m_nonce  = '0;
  bit          m_live   = 1'b0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0;
      m_idx   = 0;
      m_drop  = 0;
      foreach (m_words[i]) m_words[i] = '0;
      m_status = '0;
      m_nonce  = '0;
      m_live   = 1'b1;
    end else if (abort) begin
      m_phase = 0;
      m_idx   = 0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
             if (bus.in_first) begin
               m_words[0] = bus.in_data;
               m_idx = 1;
             end else if (m_idx == 0) begin
               m_drop = (m_drop == 255) ? 255 : m_drop + 1;
             end else begin
               m_words[m_idx] = bus.in_data;
               m_idx = (m_idx + 1) % 24;
               if (m_idx == 0) m_phase = 1;
             end
           end
        1: if (bus.job_ready) m_phase = 2;
        2: if (bus.res_valid) begin
             m_status = bus.res_found ? 32'h5555_0001 : 32'h5555_0000;
             m_nonce  = bus.res_found ? bus.res_nonce : 32'h0;
             m_phase  = 3;
           end
        3: if (bus.wb_ready) m_phase = 4;
        4: if (bus.wb_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // Every cycle after the first reset edge the DUT outputs must match the model.
  always @(negedge clk) begin
    if (m_live) begin
      logic [255:0] e_mid, e_tgt;
      logic [95:0]  e_tail;
      for (int i = 0; i < 8; i++) begin
        e_mid[255-32*i -: 32] = m_words[i];
        e_tgt[255-32*i -: 32] = m_words[12+i];
      end
      for (int i = 0; i < 3; i++) e_tail[95-32*i -: 32] = m_words[8+i];
      checkOutput("in_ready",  {255'b0, bus.in_ready},  {255'b0, m_phase == 0});
      checkOutput("job_valid", {255'b0, bus.job_valid}, {255'b0, m_phase == 1});
      checkOutput("res_ready", {255'b0, bus.res_ready}, {255'b0, m_phase == 2});
      checkOutput("wb_valid",  {255'b0, bus.wb_valid},  {255'b0, m_phase >= 3});
      checkOutput("busy",      {255'b0, busy},          {255'b0, m_phase != 0});
      checkOutput("drop_cnt",  {248'b0, drop_cnt},      256'(m_drop));
      checkOutput("job_midstate", bus.job_midstate, e_mid);
      checkOutput("job_tail",     {160'b0, bus.job_tail}, {160'b0, e_tail});
      checkOutput("job_nonce_start", {224'b0, bus.job_nonce_start}, {224'b0, m_words[11]});
      checkOutput("job_target",   bus.job_target, e_tgt);
      checkOutput("job_id",       {224'b0, bus.job_id}, {224'b0, m_words[20]});
      if (m_phase == 3) checkOutput("wb_data_status", {224'b0, bus.wb_data}, {224'b0, m_status});
      if (m_phase == 4) checkOutput("wb_data_nonce",  {224'b0, bus.wb_data}, {224'b0, m_nonce});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle's worth of inputs, then lets one active edge pass.
  task automatic applyStimulus(input logic v, input logic f, input logic [31:0] d,
                               input logic jr, input logic rv, input logic rf,
                               input logic [31:0] rn, input logic wr, input logic ab);
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.in_data   = d;
    bus.job_ready = jr;
    bus.res_valid = rv;
    bus.res_found = rf;
    bus.res_nonce = rn;
    bus.wb_ready  = wr;
    abort         = ab;
    tick();
  endtask

  task automatic idle(input int n, input logic wr);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, wr, 0);
  endtask

  task automatic sendBlock(input logic [31:0] base, input int count);
    for (int i = 0; i < count; i++) applyStimulus(1, i == 0, base + 32'(i), 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    abort = 1'b0;
    bus.in_valid = 0; bus.in_first = 0; bus.in_data = 0; bus.job_ready = 0;
    bus.res_valid = 0; bus.res_found = 0; bus.res_nonce = 0; bus.wb_ready = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("reset_in_ready", {255'b0, bus.in_ready}, 256'd1);
    checkOutput("reset_busy",     {255'b0, busy}, 256'd0);
    checkOutput("reset_wb_data",  {224'b0, bus.wb_data}, 256'd0);
    checkOutput("reset_job_id",   {224'b0, bus.job_id}, 256'd0);

    // Orphans, then a 10-word partial block restarted by a fresh in_first word.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'hBAD0 + 32'(i), 0, 0, 0, 0, 0, 0);
    sendBlock(32'h100, 10);
    sendBlock(32'h0, 24);
    checkOutput("drop_after_orphans", {248'b0, drop_cnt}, 256'd3);
    checkOutput("latency_job_valid",  {255'b0, bus.job_valid}, 256'd1);
    checkOutput("lit_midstate_w0",    {224'b0, bus.job_midstate[255:224]}, 256'h0);
    checkOutput("lit_midstate_w1",    {224'b0, bus.job_midstate[223:192]}, 256'h1);
    checkOutput("lit_tail_w10",       {224'b0, bus.job_tail[31:0]}, 256'hA);
    checkOutput("lit_nonce_start",    {224'b0, bus.job_nonce_start}, 256'hB);
    checkOutput("lit_target_w19",     {224'b0, bus.job_target[31:0]}, 256'h13);
    checkOutput("lit_job_id",         {224'b0, bus.job_id}, 256'h14);

    // Core stalls while the manager keeps offering words that must not be consumed.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'hF00D, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("lit_res_ready", {255'b0, bus.res_ready}, 256'd1);
    checkOutput("lit_no_drop_outside_collect", {248'b0, drop_cnt}, 256'd3);
    idle(2, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0);
    idle(3, 0);
    checkOutput("lit_status_found", {224'b0, bus.wb_data}, 256'h55550001);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("lit_nonce_found", {224'b0, bus.wb_data}, 256'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("lit_idle_busy", {255'b0, busy}, 256'd0);

    // Exhausted range with write-back consumed back to back.
    sendBlock(32'h20, 24);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0);
    checkOutput("lit_status_exhausted", {224'b0, bus.wb_data}, 256'h55550000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("lit_nonce_exhausted", {224'b0, bus.wb_data}, 256'h0);
    idle(2, 1);

    // Abort wins over the job handshake.
    sendBlock(32'h40, 24);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("lit_abort_job_valid", {255'b0, bus.job_valid}, 256'd0);
    checkOutput("lit_abort_in_ready",  {255'b0, bus.in_ready}, 256'd1);
    checkOutput("lit_abort_keeps_id",  {224'b0, bus.job_id}, 256'h54);

    // Abort in the nonce word of the record suppresses any further write-back.
    sendBlock(32'h60, 24);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'hCAFE0001, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("lit_abort_wb_valid", {255'b0, bus.wb_valid}, 256'd0);
    idle(4, 1);

    // Reset in the middle of a write-back.
    sendBlock(32'h80, 24);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0BADF00D, 0, 0);
    reset = 1'b0;
    idle(1, 0);
    reset = 1'b1;
    checkOutput("lit_reset_wb_valid", {255'b0, bus.wb_valid}, 256'd0);
    checkOutput("lit_reset_drop",     {248'b0, drop_cnt}, 256'd0);
    idle(3, 1);

    // Saturation of the drop counter.
    for (int i = 0; i < 300; i++) applyStimulus(1, 0, 32'(i), 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    checkOutput("lit_drop_saturated", {248'b0, drop_cnt}, 256'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/work_block_loader.md
Name: work_block_loader

Overview:
- Sits directly downstream of the SDRAM memory manager.
- Accepts the 24-word (96-byte) work block that the manager streams out of SDRAM one 32-bit word at a time, and assembles it into a hashing job.
- Hands the job to the SHA-256d nonce-search core over a valid/ready handshake, then waits for the core's result.
- Streams a 2-word result record (status, nonce) back to the manager for write-back into the nonce area of SDRAM.

Parameters:
- DATAWIDTH, 32, width of one streamed word (fixed at 32; other values unsupported).
- BLOCK_WORDS, 24, number of words in one work block.
- STATUS_FOUND, 32'h5555_0001, status word written when a nonce is found.
- STATUS_EXHAUSTED, 32'h5555_0000, status word written when the nonce range is exhausted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  streamed word valid
- in_first  in  1  qualifies in_data as word 0 of a block
- in_data  in  32  streamed word
- in_ready  out  1  loader accepts a word this cycle
- job_valid  out  1  assembled job available
- job_ready  in  1  core accepts job
- job_midstate  out  256  words 0-7; word 0 in [255:224]
- job_tail  out  96  words 8-10; word 8 in [95:64]
- job_nonce_start  out  32  word 11
- job_target  out  256  words 12-19; word 12 in [255:224]
- job_id  out  32  word 20 (words 21-23 accepted and discarded)
- res_valid  in  1  core result valid
- res_found  in  1  1 = nonce found, 0 = range exhausted
- res_nonce  in  32  winning nonce (ignored when res_found=0)
- res_ready  out  1  loader accepts result
- wb_valid  out  1  write-back word valid
- wb_data  out  32  write-back word
- wb_ready  in  1  manager consumed word (from !write_user_buffer_full)
- abort  in  1  abandon current job
- busy  out  1  state != COLLECT
- drop_cnt  out  8  saturating count of discarded words

Behaviour:
- All sequential logic is on posedge clk. Reset: reset is synchronous, active-low; clock is clk.
- Reset values:
  - state = COLLECT, word index = 0, all job registers 0.
  - job_valid = 0, res_ready = 0, wb_valid = 0, wb_data = 0, drop_cnt = 0, busy = 0, in_ready = 1 in the cycle after reset releases.
- States: COLLECT, DISPATCH, MINING, WB_STATUS, WB_NONCE.
- COLLECT:
  - in_ready = 1. A word is accepted on in_valid & in_ready.
  - in_first = 1: word is stored as word 0 and index := 1, regardless of the current index (a mid-block restart discards the partial block; no drop count for it).
  - in_first = 0 with index = 0: word is discarded and drop_cnt increments, saturating at 255.
  - Otherwise: word is stored at the current index and index increments.
  - On acceptance of word BLOCK_WORDS-1: index := 0, next state DISPATCH.
  - job_* registers update only on accepted words.
- DISPATCH:
  - job_valid = 1; job outputs held stable.
  - On job_valid & job_ready: next state MINING, job_valid drops the next cycle.
- MINING:
  - res_ready = 1. On res_valid: latch res_found and res_nonce, next state WB_STATUS.
- WB_STATUS:
  - wb_valid = 1; wb_data = STATUS_FOUND if the latched found bit is 1, else STATUS_EXHAUSTED.
  - On wb_ready: next state WB_NONCE.
- WB_NONCE:
  - wb_valid = 1; wb_data = latched nonce, or 0 if exhausted.
  - On wb_ready: next state COLLECT.
- wb_valid/wb_data stay stable until wb_ready. A 2-word record takes a minimum of 2 cycles.
- Latency: the last word accepted at cycle N gives job_valid = 1 at cycle N+1.
- abort (any state): next state COLLECT, index := 0, job_valid = res_ready = wb_valid = 0 from the next cycle. Job registers are retained but overwritten by the next block. abort has priority over every handshake in the same cycle. drop_cnt is unaffected.
- Words presented outside COLLECT see in_ready = 0 and are not consumed; they are not counted as drops.
- Reset mid-operation: immediate return to reset values on the next edge; no partial write-back word is emitted.

Test Plan:
- Reset then stream words 0x00000000..0x00000017 with in_first on word 0 -> job_valid at cycle N+1; job_midstate[255:224]=0x0, job_tail[31:0]=0xA, job_nonce_start=0xB, job_target[31:0]=0x13, job_id=0x14.
- Hold job_ready=0 for 5 cycles, then pulse it -> job outputs stable throughout; state MINING; res_ready=1.
- res_valid with res_found=1, res_nonce=0xDEADBEEF, wb_ready held low 3 cycles -> wb_data=0x55550001 held stable, then 0xDEADBEEF, then return to COLLECT with busy=0.
- res_found=0 -> write-back 0x55550000 then 0x00000000.
- 3 words with in_first=0 after reset, then in_first restart after 10 words of a block -> drop_cnt=3; the block assembles from the restart word; 300 orphan words -> drop_cnt saturates at 255.
- abort asserted in the same cycle as job_ready=1, and separately during WB_NONCE -> next cycle in COLLECT, job_valid=0, wb_valid=0, no further wb words.
